// File: rtl/led_frame_scheduler_pkg.sv
// Shared widths, defaults and FSM encoding for the LED colour RAM scheduler.
package led_frame_scheduler_pkg;

    localparam int LED_ADDR_WIDTH        = 9;
    localparam int LED_DATA_WIDTH        = 24;
    localparam int LED_COUNT_DEFAULT     = 300;
    localparam int LED_FRAME_GAP_DEFAULT = 600;

    typedef enum logic [1:0] {
        SCHED_GAP     = 2'd0,
        SCHED_FETCH   = 2'd1,
        SCHED_WAIT    = 2'd2,
        SCHED_PRESENT = 2'd3
    } sched_state_e;

    // A gap of one cycle still needs a one-bit counter.
    function automatic int gap_counter_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/led_write_holding.sv
// One-deep holding register for UART colour writes; a newer request replaces
// an unretired one and flags the loss with a one-cycle overrun pulse.
module led_write_holding
    import led_frame_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = LED_ADDR_WIDTH,
    parameter int DATA_WIDTH = LED_DATA_WIDTH
) (
    input  logic                  clock_12mhz,
    input  logic                  reset,
    input  logic                  perform_write,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  retire,
    output logic                  pending,
    output logic [ADDR_WIDTH-1:0] held_address,
    output logic [DATA_WIDTH-1:0] held_data,
    output logic                  write_overrun
);

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            pending       <= 1'b0;
            held_address  <= '0;
            held_data     <= '0;
            write_overrun <= 1'b0;
        end else begin
            // Retiring in the same cycle frees the slot, so that is not a loss.
            write_overrun <= perform_write && pending && !retire;
            if (perform_write) begin
                pending      <= 1'b1;
                held_address <= write_address;
                held_data    <= write_data;
            end else if (retire) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/led_frame_scheduler.sv
// Scans the LED colour RAM once per frame into the serializer and shares the
// single RAM port with buffered UART writes.
module led_frame_scheduler
    import led_frame_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH       = LED_ADDR_WIDTH,
    parameter int DATA_WIDTH       = LED_DATA_WIDTH,
    parameter int LED_COUNT        = LED_COUNT_DEFAULT,
    parameter int FRAME_GAP_CYCLES = LED_FRAME_GAP_DEFAULT
) (
    input  logic                  clock_12mhz,
    input  logic                  reset,
    input  logic                  perform_write,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_overrun,
    output logic                  ram_enable,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  pixel_valid,
    output logic [DATA_WIDTH-1:0] pixel_data,
    input  logic                  pixel_ready,
    output logic                  frame_start,
    output logic                  frame_done,
    output sched_state_e          debug_state
);

    localparam int GAP_W = gap_counter_width(FRAME_GAP_CYCLES);
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(FRAME_GAP_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LED_COUNT - 1);

    sched_state_e          state;
    logic [GAP_W-1:0]      gap_count;
    logic [ADDR_WIDTH-1:0] scan_address;
    logic                  deferred;
    logic                  pending;
    logic [ADDR_WIDTH-1:0] held_address;
    logic [DATA_WIDTH-1:0] held_data;
    logic                  read_grant;
    logic                  write_grant;

    led_write_holding #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_write_holding (
        .clock_12mhz   (clock_12mhz),
        .reset         (reset),
        .perform_write (perform_write),
        .write_address (write_address),
        .write_data    (write_data),
        .retire        (write_grant),
        .pending       (pending),
        .held_address  (held_address),
        .held_data     (held_data),
        .write_overrun (write_overrun)
    );

    // A fetch yields to a pending write once, then wins on the retry.
    always_comb begin
        read_grant  = (state == SCHED_FETCH) && (!pending || deferred);
        write_grant = pending && !read_grant;
    end

    assign ram_enable       = read_grant || write_grant;
    assign ram_write_enable = write_grant;
    assign ram_address      = write_grant ? held_address : (read_grant ? scan_address : '0);
    assign ram_write_data   = write_grant ? held_data : '0;
    assign debug_state      = state;

    // Pixel handshake: pixel_valid rises with pixel_data already stable, both
    // hold until a cycle with pixel_valid && pixel_ready, which is the transfer;
    // pixel_valid never drops without a transfer except on reset.
    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            state        <= SCHED_GAP;
            gap_count    <= '0;
            scan_address <= '0;
            deferred     <= 1'b0;
            pixel_valid  <= 1'b0;
            pixel_data   <= '0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                SCHED_GAP: begin
                    if (gap_count == GAP_LAST) begin
                        gap_count    <= '0;
                        scan_address <= '0;
                        frame_start  <= 1'b1;
                        state        <= SCHED_FETCH;
                    end else begin
                        gap_count <= gap_count + GAP_W'(1);
                    end
                end
                SCHED_FETCH: begin
                    if (read_grant) begin
                        deferred <= 1'b0;
                        state    <= SCHED_WAIT;
                    end else begin
                        deferred <= 1'b1;
                    end
                end
                SCHED_WAIT: begin
                    pixel_data  <= ram_read_data;
                    pixel_valid <= 1'b1;
                    state       <= SCHED_PRESENT;
                end
                SCHED_PRESENT: begin
                    if (pixel_ready) begin
                        pixel_valid <= 1'b0;
                        if (scan_address == LAST_ADDR) begin
                            frame_done <= 1'b1;
                            state      <= SCHED_GAP;
                        end else begin
                            scan_address <= scan_address + ADDR_WIDTH'(1);
                            state        <= SCHED_FETCH;
                        end
                    end
                end
                default: state <= SCHED_GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler with LED_COUNT=4, FRAME_GAP_CYCLES=10.
module tb_led_frame_scheduler;
    import led_frame_scheduler_pkg::*;

    localparam int NCYC = 146;

    logic        clk = 1'b0;
    logic        reset;
    logic        preload;
    logic        perform_write;
    logic [8:0]  write_address;
    logic [23:0] write_data;
    logic        write_overrun;
    logic        ram_enable;
    logic        ram_write_enable;
    logic [8:0]  ram_address;
    logic [23:0] ram_write_data;
    logic [23:0] ram_read_data;
    logic        pixel_valid;
    logic [23:0] pixel_data;
    logic        pixel_ready;
    logic        frame_start;
    logic        frame_done;
    sched_state_e debug_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_frame_scheduler #(
        .ADDR_WIDTH       (9),
        .DATA_WIDTH       (24),
        .LED_COUNT        (4),
        .FRAME_GAP_CYCLES (10)
    ) dut (
        .clock_12mhz      (clk),
        .reset            (reset),
        .perform_write    (perform_write),
        .write_address    (write_address),
        .write_data       (write_data),
        .write_overrun    (write_overrun),
        .ram_enable       (ram_enable),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_write_data   (ram_write_data),
        .ram_read_data    (ram_read_data),
        .pixel_valid      (pixel_valid),
        .pixel_data       (pixel_data),
        .pixel_ready      (pixel_ready),
        .frame_start      (frame_start),
        .frame_done       (frame_done),
        .debug_state      (debug_state)
    );

    // RAM environment: synchronous single-port, read data valid next cycle.
    logic [23:0] mem [512];
    int writes_to_5 = 0;
    int writes_to_9 = 0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
            mem[0] <= 24'h111111;
            mem[1] <= 24'h222222;
            mem[2] <= 24'h333333;
            mem[3] <= 24'h444444;
        end else if (ram_enable) begin
            if (ram_write_enable) begin
                mem[ram_address] <= ram_write_data;
                if (ram_address == 9'd5) writes_to_5 <= writes_to_5 + 1;
                if (ram_address == 9'd9) writes_to_9 <= writes_to_9 + 1;
            end else begin
                ram_read_data <= mem[ram_address];
            end
        end
    end

    // Per-cycle trace, sampled on the falling edge.
    logic         tr_fs [NCYC];
    logic         tr_fd [NCYC];
    logic         tr_pv [NCYC];
    logic [23:0]  tr_pd [NCYC];
    logic         tr_re [NCYC];
    logic         tr_we [NCYC];
    logic [8:0]   tr_ra [NCYC];
    logic [23:0]  tr_wd [NCYC];
    logic         tr_ov [NCYC];
    sched_state_e tr_st [NCYC];

    typedef struct {
        int          cyc;
        logic        all_zero;
        logic        fs;
        logic        fd;
        logic        pv;
        logic [23:0] pd;
        logic        re;
        logic        we;
        logic [8:0]  ra;
        logic [23:0] wd;
        logic        ov;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int cyc, input logic fs, input logic fd, input logic pv,
                                input logic [23:0] pd, input logic re, input logic we,
                                input logic [8:0] ra, input logic [23:0] wd, input logic ov);
        vec_t v;
        v.cyc = cyc; v.all_zero = 1'b0; v.fs = fs; v.fd = fd; v.pv = pv; v.pd = pd;
        v.re = re; v.we = we; v.ra = ra; v.wd = wd; v.ov = ov;
        return v;
    endfunction

    function automatic vec_t zr(input int cyc);
        vec_t v;
        v = mk(cyc, 0, 0, 0, 24'h0, 0, 0, 9'd0, 24'h0, 0);
        v.all_zero = 1'b1;
        return v;
    endfunction

    task automatic drive_cycle(input int c);
        perform_write = 1'b0;
        write_address = '0;
        write_data    = '0;
        reset         = (c == 128 || c == 129);
        pixel_ready   = !((c >= 83 && c <= 102) || c == 128);
        case (c)
            24:  begin perform_write = 1'b1; write_address = 9'd2; write_data = 24'h00FF00; end
            53:  begin perform_write = 1'b1; write_address = 9'd1; write_data = 24'hABCDEF; end
            54:  begin perform_write = 1'b1; write_address = 9'd3; write_data = 24'h123456; end
            76:  begin perform_write = 1'b1; write_address = 9'd7; write_data = 24'h777777; end
            77:  begin perform_write = 1'b1; write_address = 9'd5; write_data = 24'h555555; end
            78:  begin perform_write = 1'b1; write_address = 9'd6; write_data = 24'h666666; end
            90:  begin perform_write = 1'b1; write_address = 9'd1; write_data = 24'h0F0F0F; end
            128: begin perform_write = 1'b1; write_address = 9'd9; write_data = 24'h999999; end
            default: ;
        endcase
    endtask

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    initial begin
        int cnt;
        logic ok;

        vecs.push_back(zr(0));
        vecs.push_back(mk(9,   0, 0, 0, 24'h0,      0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(10,  1, 0, 0, 24'h0,      1, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(11,  0, 0, 0, 24'h0,      0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(12,  0, 0, 1, 24'h111111, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(13,  0, 0, 0, 24'h0,      1, 0, 9'd1, 24'h0,      0));
        vecs.push_back(mk(15,  0, 0, 1, 24'h222222, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(18,  0, 0, 1, 24'h333333, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(19,  0, 0, 0, 24'h0,      1, 0, 9'd3, 24'h0,      0));
        vecs.push_back(mk(21,  0, 0, 1, 24'h444444, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(22,  0, 1, 0, 24'h0,      0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(23,  0, 0, 0, 24'h0,      0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(25,  0, 0, 0, 24'h0,      1, 1, 9'd2, 24'h00FF00, 0));
        vecs.push_back(mk(31,  0, 0, 0, 24'h0,      0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(32,  1, 0, 0, 24'h0,      1, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(34,  0, 0, 1, 24'h111111, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(40,  0, 0, 1, 24'h00FF00, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(43,  0, 0, 1, 24'h444444, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(44,  0, 1, 0, 24'h0,      0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(53,  0, 0, 0, 24'h0,      0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(54,  1, 0, 0, 24'h0,      1, 1, 9'd1, 24'hABCDEF, 0));
        vecs.push_back(mk(55,  0, 0, 0, 24'h0,      1, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(56,  0, 0, 0, 24'h0,      1, 1, 9'd3, 24'h123456, 0));
        vecs.push_back(mk(57,  0, 0, 1, 24'h111111, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(58,  0, 0, 0, 24'h0,      1, 0, 9'd1, 24'h0,      0));
        vecs.push_back(mk(60,  0, 0, 1, 24'hABCDEF, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(63,  0, 0, 1, 24'h00FF00, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(66,  0, 0, 1, 24'h123456, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(67,  0, 1, 0, 24'h0,      0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(77,  1, 0, 0, 24'h0,      1, 1, 9'd7, 24'h777777, 0));
        vecs.push_back(mk(78,  0, 0, 0, 24'h0,      1, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(79,  0, 0, 0, 24'h0,      1, 1, 9'd6, 24'h666666, 1));
        vecs.push_back(mk(80,  0, 0, 1, 24'h111111, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(83,  0, 0, 1, 24'hABCDEF, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(91,  0, 0, 1, 24'hABCDEF, 1, 1, 9'd1, 24'h0F0F0F, 0));
        vecs.push_back(mk(102, 0, 0, 1, 24'hABCDEF, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(103, 0, 0, 1, 24'hABCDEF, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(104, 0, 0, 0, 24'h0,      1, 0, 9'd2, 24'h0,      0));
        vecs.push_back(mk(106, 0, 0, 1, 24'h00FF00, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(109, 0, 0, 1, 24'h123456, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(110, 0, 1, 0, 24'h0,      0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(120, 1, 0, 0, 24'h0,      1, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(125, 0, 0, 1, 24'h0F0F0F, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(128, 0, 0, 1, 24'h00FF00, 0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(zr(129));
        vecs.push_back(zr(130));
        vecs.push_back(mk(139, 0, 0, 0, 24'h0,      0, 0, 9'd0, 24'h0,      0));
        vecs.push_back(mk(140, 1, 0, 0, 24'h0,      1, 0, 9'd0, 24'h0,      0));

        // Clock/reset: hold reset while the RAM model is preloaded.
        reset         = 1'b1;
        preload       = 1'b1;
        perform_write = 1'b0;
        write_address = '0;
        write_data    = '0;
        pixel_ready   = 1'b1;
        repeat (3) @(negedge clk);
        preload = 1'b0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            tr_fs[c] = frame_start;
            tr_fd[c] = frame_done;
            tr_pv[c] = pixel_valid;
            tr_pd[c] = pixel_data;
            tr_re[c] = ram_enable;
            tr_we[c] = ram_write_enable;
            tr_ra[c] = ram_address;
            tr_wd[c] = ram_write_data;
            tr_ov[c] = write_overrun;
            tr_st[c] = debug_state;
            drive_cycle(c);
        end

        foreach (vecs[i]) begin
            vec_t e;
            int   c;
            e = vecs[i];
            c = e.cyc;
            ok = (tr_fs[c] == e.fs) && (tr_fd[c] == e.fd) && (tr_pv[c] == e.pv) &&
                 (tr_re[c] == e.re) && (tr_we[c] == e.we) && (tr_ov[c] == e.ov);
            if (e.pv || e.all_zero) ok = ok && (tr_pd[c] == e.pd);
            if (e.re || e.all_zero) ok = ok && (tr_ra[c] == e.ra);
            if (e.we || e.all_zero) ok = ok && (tr_wd[c] == e.wd);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL cycle_%0d: got fs=%b fd=%b pv=%b pd=%h re=%b we=%b ra=%0d wd=%h ov=%b, expected fs=%b fd=%b pv=%b pd=%h re=%b we=%b ra=%0d wd=%h ov=%b",
                         c, tr_fs[c], tr_fd[c], tr_pv[c], tr_pd[c], tr_re[c], tr_we[c], tr_ra[c], tr_wd[c], tr_ov[c],
                         e.fs, e.fd, e.pv, e.pd, e.re, e.we, e.ra, e.wd, e.ov);
            end
        end

        cnt = 0;
        for (int c = 0; c < NCYC; c++) cnt += int'(tr_ov[c]);
        check("overrun_pulses", cnt, 1);

        cnt = 0;
        for (int c = 0; c < NCYC; c++) cnt += int'(tr_fd[c]);
        check("frame_done_pulses", cnt, 4);

        cnt = 0;
        for (int c = 0; c < NCYC; c++) cnt += int'(tr_fs[c]);
        check("frame_start_pulses", cnt, 6);

        cnt = 0;
        for (int c = 128; c < NCYC; c++) cnt += int'(tr_fd[c]);
        check("no_done_after_reset", cnt, 0);

        check("writes_to_addr5", writes_to_5, 0);
        check("discarded_write_addr9", writes_to_9, 0);
        check("mem6_value", int'(mem[6]), int'(24'h666666));
        check("mem1_value", int'(mem[1]), int'(24'h0F0F0F));

        cnt = 0;
        for (int c = 83; c <= 103; c++)
            if (!tr_pv[c] || tr_pd[c] != 24'hABCDEF) cnt++;
        check("backpressure_stable_cycles_bad", cnt, 0);

        cnt = 0;
        for (int c = 84; c <= 103; c++)
            if (tr_re[c] && !tr_we[c]) cnt++;
        check("backpressure_reads", cnt, 0);

        check("state_wait_c11", int'(tr_st[11]), int'(SCHED_WAIT));
        check("state_gap_c129", int'(tr_st[129]), int'(SCHED_GAP));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
